// File: rtl/button_press_classifier_if.sv
// Signal bundle between the button debouncer/consumer side and the press classifier.
// The classifier takes the slave view; whoever drives the button level takes master.
interface button_press_classifier_if;
   logic       btn_in;
   logic       short_press;
   logic       long_press;
   logic       double_press;
   logic       long_held;
   logic [7:0] event_count;

   modport master (
      output btn_in,
      input  short_press,
      input  long_press,
      input  double_press,
      input  long_held,
      input  event_count
   );

   modport slave (
      input  btn_in,
      output short_press,
      output long_press,
      output double_press,
      output long_held,
      output event_count
   );
endinterface

// File: rtl/button_press_classifier.sv
// Classifies a debounced button level into short, long and double presses,
// emitting one registered pulse per gesture plus a held-long level and event count.
module button_press_classifier #(
   parameter int                CNT_W      = 24,
   parameter logic [CNT_W-1:0]  LONG_TICKS = 24'd5_000_000,
   parameter logic [CNT_W-1:0]  GAP_TICKS  = 24'd2_500_000
) (
   input  logic                  clk,
   input  logic                  rst,
   button_press_classifier_if.slave bus
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] PRESS1    = 3'd1;
   localparam logic [2:0] LONG_HELD = 3'd2;
   localparam logic [2:0] WAIT_GAP  = 3'd3;
   localparam logic [2:0] PRESS2    = 3'd4;

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] LONG_LAST = LONG_TICKS - ONE;
   localparam logic [CNT_W-1:0] GAP_LAST  = GAP_TICKS - ONE;

   logic [2:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             btn_q_reg;
   logic             short_reg, short_next;
   logic             long_reg, long_next;
   logic             double_reg, double_next;
   logic             held_reg, held_next;
   logic [7:0]       count_reg, count_next;

   logic rise;
   logic fall;

   assign rise = bus.btn_in & ~btn_q_reg;
   assign fall = ~bus.btn_in & btn_q_reg;

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      short_next  = 1'b0;
      long_next   = 1'b0;
      double_next = 1'b0;
      held_next   = held_reg;

      case (state_reg)
         IDLE: begin
            held_next = 1'b0;
            if (rise) begin
               state_next = PRESS1;
               cnt_next   = '0;
            end
         end
         PRESS1: begin
            // A release on the qualifying edge wins: the gesture stays short.
            if (fall) begin
               state_next = WAIT_GAP;
               cnt_next   = '0;
            end else if (cnt_reg == LONG_LAST) begin
               long_next  = 1'b1;
               held_next  = 1'b1;
               state_next = LONG_HELD;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + ONE;
            end
         end
         LONG_HELD: begin
            held_next = 1'b1;
            if (fall) begin
               held_next  = 1'b0;
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
         WAIT_GAP: begin
            // A second press on the expiry edge still makes a double.
            if (rise) begin
               state_next = PRESS2;
               cnt_next   = '0;
            end else if (cnt_reg == GAP_LAST) begin
               short_next = 1'b1;
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + ONE;
            end
         end
         PRESS2: begin
            if (fall) begin
               double_next = 1'b1;
               state_next  = IDLE;
               cnt_next    = '0;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
            held_next  = 1'b0;
         end
      endcase

      count_next = count_reg;
      if (short_next | long_next | double_next) begin
         count_next = count_reg + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         btn_q_reg  <= 1'b0;
         short_reg  <= 1'b0;
         long_reg   <= 1'b0;
         double_reg <= 1'b0;
         held_reg   <= 1'b0;
         count_reg  <= 8'd0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         btn_q_reg  <= bus.btn_in;
         short_reg  <= short_next;
         long_reg   <= long_next;
         double_reg <= double_next;
         held_reg   <= held_next;
         count_reg  <= count_next;
      end
   end

   assign bus.short_press  = short_reg;
   assign bus.long_press   = long_reg;
   assign bus.double_press = double_reg;
   assign bus.long_held    = held_reg;
   assign bus.event_count  = count_reg;

endmodule
